// File: rtl/uart_xmt_scheduler_pkg.sv
// Shared UART scheduler types: FSM state encoding, default byte width, clog2.
// Used by uart_xmt_scheduler and uart_rr_arbiter.
package uart_xmt_scheduler_pkg;

    localparam int UART_WORD_SIZE = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        READY = 3'd2,
        START = 3'd3,
        WAIT  = 3'd4
    } xmt_state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Request arbiter for the UART transmit scheduler: one-hot winner plus index.
// UART_XMT_SCHED_FIXED_PRIO_EN selects lowest-index priority and drops the pointer.
module uart_rr_arbiter
    import uart_xmt_scheduler_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IW      = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
`ifndef UART_XMT_SCHED_FIXED_PRIO_EN
    input  logic [IW-1:0]      ptr_i,
`endif
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IW-1:0]      idx_o
);

    logic found;

`ifdef UART_XMT_SCHED_FIXED_PRIO_EN

    always_comb begin
        found = 1'b0;
        idx_o = '0;
        // Scan downward so the lowest requesting index is the final winner.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_i[k]) begin
                found = 1'b1;
                idx_o = IW'(k);
            end
        end
        gnt_o = '0;
        gnt_o[idx_o] = found;
    end

`else

    logic [IW-1:0] cand;

    always_comb begin
        found = 1'b0;
        idx_o = '0;
        cand  = '0;
        // Search starts one past the last winner and wraps modulo NUM_REQ.
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IW'((int'(ptr_i) + k) % NUM_REQ);
            if (!found && req_i[cand]) begin
                found = 1'b1;
                idx_o = cand;
            end
        end
        gnt_o = '0;
        gnt_o[idx_o] = found;
    end

`endif

endmodule

// File: rtl/uart_xmt_scheduler.sv
// Shares one UART transmitter among NUM_REQ byte requesters.
// Build option UART_XMT_SCHED_FIXED_PRIO_EN: fixed priority instead of round-robin.
module uart_xmt_scheduler
    import uart_xmt_scheduler_pkg::*;
#(
    parameter  int NUM_REQ      = 4,
    parameter  int word_size    = UART_WORD_SIZE,
    parameter  int FRAME_CYCLES = 10,
    localparam int IW           = clog2(NUM_REQ)
) (
    input  logic                           Clock,
    input  logic                           rst_b,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*word_size-1:0]   req_data,
    output logic [NUM_REQ-1:0]             ack,
    output logic [word_size-1:0]           Data_Bus,
    output logic                           Load_XMT_datareg,
    output logic                           Byte_ready,
    output logic                           T_byte,
    output logic                           busy,
    output logic [IW-1:0]                  grant_id
);

    localparam int CW = clog2(FRAME_CYCLES + 1);

    xmt_state_e             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [word_size-1:0]   data_q, data_d;
    logic [IW-1:0]          grant_q, grant_d;

    logic [NUM_REQ-1:0]     win_gnt;
    logic [IW-1:0]          win_idx;
    logic [word_size-1:0]   win_data;

`ifndef UART_XMT_SCHED_FIXED_PRIO_EN
    logic [IW-1:0]          ptr_q, ptr_d;
`endif

    uart_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req_i   (req),
`ifndef UART_XMT_SCHED_FIXED_PRIO_EN
        .ptr_i   (ptr_q),
`endif
        .gnt_o   (win_gnt),
        .idx_o   (win_idx)
    );

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_gnt[i]) begin
                win_data = win_data | req_data[i*word_size +: word_size];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        grant_d = grant_q;
`ifndef UART_XMT_SCHED_FIXED_PRIO_EN
        ptr_d   = ptr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (|win_gnt) begin
                    data_d  = win_data;
                    grant_d = win_idx;
`ifndef UART_XMT_SCHED_FIXED_PRIO_EN
                    ptr_d   = win_idx;
`endif
                    state_d = LOAD;
                end
            end
            LOAD:  state_d = READY;
            READY: state_d = START;
            START: begin
                cnt_d   = CW'(FRAME_CYCLES - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (rst_b) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            grant_q <= '0;
`ifndef UART_XMT_SCHED_FIXED_PRIO_EN
            ptr_q   <= IW'(NUM_REQ - 1);
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            grant_q <= grant_d;
`ifndef UART_XMT_SCHED_FIXED_PRIO_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    // Strobes decode from registered state only; no path from req.
    always_comb begin
        ack = '0;
        if (state_q == LOAD) begin
            ack[grant_q] = 1'b1;
        end
    end

    assign Load_XMT_datareg = (state_q == LOAD);
    assign Byte_ready       = (state_q == READY);
    assign T_byte           = (state_q == START);
    assign busy             = (state_q != IDLE);
    assign Data_Bus         = data_q;
    assign grant_id         = grant_q;

endmodule

// File: tb/tb_uart_xmt_scheduler.sv
// Directed testbench for uart_xmt_scheduler (NUM_REQ=4, word_size=8, FRAME_CYCLES=10).
// Expectations follow the build selected by UART_XMT_SCHED_FIXED_PRIO_EN.
module tb_uart_xmt_scheduler;

    localparam int NR = 4;
    localparam int WS = 8;
    localparam int FC = 10;

    logic              Clock = 1'b0;
    logic              rst_b = 1'b1;
    logic [NR-1:0]     req = '0;
    logic [NR*WS-1:0]  req_data = '0;
    logic [NR-1:0]     ack;
    logic [WS-1:0]     Data_Bus;
    logic              Load_XMT_datareg;
    logic              Byte_ready;
    logic              T_byte;
    logic              busy;
    logic [1:0]        grant_id;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 Clock = ~Clock;

    uart_xmt_scheduler #(
        .NUM_REQ      (NR),
        .word_size    (WS),
        .FRAME_CYCLES (FC)
    ) dut (
        .Clock            (Clock),
        .rst_b            (rst_b),
        .req              (req),
        .req_data         (req_data),
        .ack              (ack),
        .Data_Bus         (Data_Bus),
        .Load_XMT_datareg (Load_XMT_datareg),
        .Byte_ready       (Byte_ready),
        .T_byte           (T_byte),
        .busy             (busy),
        .grant_id         (grant_id)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic wait_load(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!Load_XMT_datareg && n < 40);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 40) begin
            step();
            n++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        int exp;
        int hits;

        // Reset state
        rst_b = 1'b1;
        step();
        step();
        check("rst_busy", 32'(busy), 0);
        check("rst_load", 32'(Load_XMT_datareg), 0);
        check("rst_ack", 32'(ack), 0);
        check("rst_data", 32'(Data_Bus), 0);
        check("rst_gid", 32'(grant_id), 0);

        // 1: single requester 2, latency and frame spacing
        rst_b    = 1'b0;
        req_data = {8'h00, 8'hA5, 8'h00, 8'h00};
        req      = 4'b0100;
        wait_load(n);
        check("t1_lat", n, 1);
        check("t1_ack", 32'(ack), 32'h4);
        check("t1_data", 32'(Data_Bus), 32'hA5);
        check("t1_gid", 32'(grant_id), 2);
        req = '0;
        step();
        check("t1_rdy", 32'(Byte_ready), 1);
        check("t1_ack_off", 32'(ack), 0);
        step();
        check("t1_tbyte", 32'(T_byte), 1);
        check("t1_busy", 32'(busy), 1);
        req_data[23:16] = 8'h3C;
        req = 4'b0100;
        wait_load(n);
        check("t1_space", n + 2, FC + 4);
        check("t1_data2", 32'(Data_Bus), 32'h3C);
        req = '0;
        wait_idle("t1_idle");

        // 2/3: all four requesting continuously
        rst_b = 1'b1;
        step();
        rst_b    = 1'b0;
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        req      = 4'hF;
        for (int k = 0; k < 5; k++) begin
            wait_load(n);
            check("t2_space", n, (k == 0) ? 1 : FC + 4);
`ifdef UART_XMT_SCHED_FIXED_PRIO_EN
            exp = 0;
`else
            exp = k % NR;
`endif
            check("t2_gid", 32'(grant_id), exp);
            check("t2_ack", 32'(ack), 32'(1 << exp));
            check("t2_data", 32'(Data_Bus), 32'((exp + 1) * 32'h11));
        end
        req = 4'b1110;
        wait_load(n);
        check("t2_space_last", n, FC + 4);
        check("t2_gid_last", 32'(grant_id), 1);
        check("t2_data_last", 32'(Data_Bus), 32'h22);

        // 4: reset in WAIT with requests pending
        repeat (5) step();
        rst_b = 1'b1;
        req   = 4'hF;
        step();
        check("t4_busy", 32'(busy), 0);
        check("t4_ack", 32'(ack), 0);
        check("t4_load", 32'(Load_XMT_datareg), 0);
        check("t4_rdy", 32'(Byte_ready), 0);
        check("t4_tbyte", 32'(T_byte), 0);
        check("t4_data", 32'(Data_Bus), 0);
        check("t4_gid", 32'(grant_id), 0);
        rst_b = 1'b0;
        wait_load(n);
        check("t4_lat", n, 1);
        check("t4_gid_first", 32'(grant_id), 0);
        check("t4_data_first", 32'(Data_Bus), 32'h11);

        // 5: req[1] pulsed during the frame and withdrawn before grant
        req = '0;
        repeat (4) step();
        req = 4'b0010;
        step();
        step();
        req  = '0;
        hits = 0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (Load_XMT_datareg || ack != '0) hits++;
        end
        check("t5_no_grant", hits, 0);
        check("t5_idle", 32'(busy), 0);

        // 6: req[3] held past its ack is served again
        req_data[31:24] = 8'h5A;
        req = 4'b1000;
        wait_load(n);
        check("t6_lat", n, 1);
        check("t6_gid", 32'(grant_id), 3);
        check("t6_ack", 32'(ack), 32'h8);
        check("t6_data", 32'(Data_Bus), 32'h5A);
        wait_load(n);
        check("t6_space", n, FC + 4);
        check("t6_gid2", 32'(grant_id), 3);
        check("t6_ack2", 32'(ack), 32'h8);
        check("t6_data2", 32'(Data_Bus), 32'h5A);
        req = '0;
        wait_idle("t6_idle");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
